sap_bus_arbiter: RTL and testbench
==================================

// Module: sap_bus_arbiter
// PURPOSE
//  Parametrised, registered successor to the SAP-1 combinational bus multiplexer.
//  Selects one of NSRC source buses onto the shared W-bus using per-source enables,
//  with fixed priority (lowest index wins). Registers the result and reports contention.
//  Sits between the datapath sources (ULA, AR, IR, MEM, PC, ...) and all bus loaders.
// PARAMETERS
//  WIDTH     8  data width of every source and of BUS_OUT
//  NSRC      5  number of bus sources (>=2)
//  HOLD      1  1: BUS_OUT keeps its last value when no enable; 0: BUS_OUT clears to 0
//  CNTW      8  width of the saturating contention counter
//  SELW      $clog2(NSRC)  derived; width of BUS_SEL; not overridden
// PORTS
//  CLK        in   1            system clock, rising edge
//  RST_N      in   1            asynchronous, active-low reset
//  EN         in   NSRC         per-source drive enable; bit i = source i
//  SRC_DATA   in   NSRC*WIDTH   flattened sources; source i = SRC_DATA[i*WIDTH +: WIDTH]
//  CLR_ERR    in   1            synchronous clear of CONT_STICKY and CONT_COUNT
//  BUS_OUT    out  WIDTH        registered bus value
//  BUS_VALID  out  1            registered; 1 when BUS_OUT was loaded from a source last edge
//  BUS_SEL    out  SELW         registered index of the granted source
//  CONTENTION out  1            registered single-cycle flag: >1 enable seen last edge
//  CONT_STICKY out 1            sticky contention flag
//  CONT_COUNT out  CNTW         saturating count of contention cycles
// BEHAVIOUR
//  - Reset (RST_N=0, async): BUS_OUT=0, BUS_VALID=0, BUS_SEL=0, CONTENTION=0,
//    CONT_STICKY=0, CONT_COUNT=0. Release is synchronous to the next rising CLK.
//  - Grant: g = lowest i with EN[i]=1. Combinational; registered on rising CLK.
//  - Latency: exactly 1 cycle, EN/SRC_DATA at edge k -> BUS_OUT/BUS_SEL/BUS_VALID after edge k.
//  - Any EN set: BUS_OUT<=SRC_DATA[g], BUS_SEL<=g, BUS_VALID<=1.
//  - No EN set: BUS_VALID<=0, BUS_SEL holds; BUS_OUT holds (HOLD=1) or <=0 (HOLD=0).
//  - Contention: popcount(EN)>1 -> CONTENTION<=1 for that cycle only. Grant still goes to
//    lowest index, so the bus stays deterministic.
//  - CONT_STICKY<=1 on any contention. It stays set until CLR_ERR or reset.
//  - CONT_COUNT increments by 1 per contention cycle and saturates at 2^CNTW-1 (no wrap).
//  - Simultaneous CLR_ERR and contention: clear wins for the sticky flag and the counter,
//    so both read 0 next cycle. CONTENTION still pulses 1.
//  - CLR_ERR does not affect BUS_OUT/BUS_VALID/BUS_SEL/CONTENTION.
//  - Reset asserted mid-transfer: all outputs go to reset values immediately. No partial state.
//  - Single-source cycles never touch CONTENTION/sticky/counter.
// STRUCTURE
//  - Shared package sap_bus_pkg: source index constants SRC_ULA=0, SRC_AR=1, SRC_IR=2,
//    SRC_MEM=3, SRC_PC=4; default WIDTH/NSRC constants. Control-word bit positions
//    (EN_ULA=0, EN_AR=3, EN_IR=6, EN_MEM=8, EN_PC=10) live there for the control
//    unit that builds EN.
//  - One sub-module, sap_prio_enc #(NSRC): EN -> {any, grant index, multi}. It is
//    combinational.
//  - The top level holds the output registers, sticky flag and saturating counter.
// TESTING
//  1. Reset: hold RST_N=0 with random EN/data -> all outputs 0; release -> still 0 until first EN.
//  2. Single source: EN=5'b00100, src2=8'hA5 -> next cycle BUS_OUT=8'hA5, BUS_SEL=2,
//     BUS_VALID=1, CONTENTION=0.
//  3. Idle: after step 2, EN=0 -> BUS_VALID=0, BUS_OUT=8'hA5 (HOLD=1) / 8'h00 (HOLD=0).
//  4. Contention: EN=5'b10010, src1=8'h11, src4=8'h44 -> BUS_OUT=8'h11, BUS_SEL=1,
//     CONTENTION=1 for one cycle, CONT_STICKY=1, CONT_COUNT=1.
//  5. Saturation/clear: CNTW=2, 5 contention cycles -> CONT_COUNT=3. Then CLR_ERR together
//     with contention -> CONT_COUNT=0, CONT_STICKY=0, CONTENTION=1.
//  6. Async reset mid-stream: RST_N pulse between edges during EN=5'b00001 -> outputs
//     clear immediately. Grants resume one edge after release.

Source files
------------

// File: rtl/sap_bus_pkg.sv
// Shared constants for the SAP W-bus: source indices, default sizes and the
// control-word bit positions the control unit uses to build the enable vector.
package sap_bus_pkg;

  localparam int unsigned SAP_WIDTH = 8;
  localparam int unsigned SAP_NSRC  = 5;

  // Bus source indices; a lower index wins when several sources drive at once.
  typedef enum logic [2:0] {
    SRC_ULA = 3'd0,
    SRC_AR  = 3'd1,
    SRC_IR  = 3'd2,
    SRC_MEM = 3'd3,
    SRC_PC  = 3'd4
  } sap_src_e;

  // Positions of the bus-drive enables inside the control word.
  localparam int unsigned EN_ULA = 0;
  localparam int unsigned EN_AR  = 3;
  localparam int unsigned EN_IR  = 6;
  localparam int unsigned EN_MEM = 8;
  localparam int unsigned EN_PC  = 10;

  // Control-word bit that carries the drive enable of a given source.
  function automatic int unsigned ctrl_en_bit(sap_src_e src);
    unique case (src)
      SRC_ULA: return EN_ULA;
      SRC_AR:  return EN_AR;
      SRC_IR:  return EN_IR;
      SRC_MEM: return EN_MEM;
      SRC_PC:  return EN_PC;
      default: return EN_ULA;
    endcase
  endfunction

endpackage

// File: rtl/sap_prio_enc.sv
// Fixed-priority encoder for the bus enables: lowest set index is granted.
// Also flags when more than one enable is set.
module sap_prio_enc import sap_bus_pkg::*; #(
  parameter int unsigned NSRC = SAP_NSRC,
  localparam int unsigned SELW = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] en,
  output logic            any,
  output logic [SELW-1:0] grant,
  output logic            multi
);

  // Scan from the top so the lowest set index is the last (winning) write.
  always_comb begin
    grant = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (en[i]) grant = SELW'(i);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  always_comb begin
    any   = |en;
    multi = |(en & (en - NSRC'(1)));
  end

endmodule

// File: rtl/sap_bus_arbiter.sv
// Registered W-bus arbiter: muxes the granted source onto the bus one cycle
// later and tracks drive contention with a pulse, a sticky flag and a
// saturating counter.
module sap_bus_arbiter import sap_bus_pkg::*; #(
  parameter int unsigned WIDTH = SAP_WIDTH,
  parameter int unsigned NSRC  = SAP_NSRC,
  parameter int unsigned HOLD  = 1,
  parameter int unsigned CNTW  = 8,
  localparam int unsigned SELW = $clog2(NSRC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC-1:0]       en,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic                  clr_err,
  output logic [WIDTH-1:0]      bus_out,
  output logic                  bus_valid,
  output logic [SELW-1:0]       bus_sel,
  output logic                  contention,
  output logic                  cont_sticky,
  output logic [CNTW-1:0]       cont_count
);

  logic            any;
  logic            multi;
  logic [SELW-1:0] grant;

  logic [WIDTH-1:0] src_arr [NSRC];

  logic [WIDTH-1:0] bus_out_q, bus_out_d;
  logic             bus_valid_q, bus_valid_d;
  logic [SELW-1:0]  bus_sel_q, bus_sel_d;
  logic             cont_q, cont_d;
  logic             sticky_q, sticky_d;
  logic [CNTW-1:0]  count_q, count_d;

  for (genvar i = 0; i < int'(NSRC); i++) begin : g_src
    assign src_arr[i] = src_data[i*WIDTH +: WIDTH];
  end

  sap_prio_enc #(
    .NSRC (NSRC)
  ) u_prio_enc (
    .en    (en),
    .any   (any),
    .grant (grant),
    .multi (multi)
  );

  // Next bus state: load the granted source, otherwise hold or clear the data.
  always_comb begin
    bus_out_d   = bus_out_q;
    bus_valid_d = 1'b0;
    bus_sel_d   = bus_sel_q;
    if (any) begin
      bus_out_d   = src_arr[grant];
      bus_valid_d = 1'b1;
      bus_sel_d   = grant;
    end else if (HOLD == 0) begin
      bus_out_d = '0;
    end
  end

  // Contention tracking; clear beats a coincident contention for sticky/count.
  always_comb begin
    cont_d   = multi;
    sticky_d = sticky_q;
    count_d  = count_q;
    if (clr_err) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end else if (multi) begin
      sticky_d = 1'b1;
      if (count_q != '1) count_d = count_q + CNTW'(1);
    end
  end

  // All outputs are registered and cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      bus_sel_q   <= '0;
      cont_q      <= 1'b0;
      sticky_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
      bus_sel_q   <= bus_sel_d;
      cont_q      <= cont_d;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
    end
  end

  assign bus_out     = bus_out_q;
  assign bus_valid   = bus_valid_q;
  assign bus_sel     = bus_sel_q;
  assign contention  = cont_q;
  assign cont_sticky = sticky_q;
  assign cont_count  = count_q;

endmodule

// File: tb/tb_sap_bus_arbiter.sv
// Bench for sap_bus_arbiter: a HOLD=1/CNTW=2 instance and a HOLD=0/CNTW=8
// instance share stimulus; a reference model queues expected outputs per edge.
module tb_sap_bus_arbiter;
  import sap_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  en = '0;
  logic [39:0] src_data = '0;
  logic        clr_err = 1'b0;

  logic [7:0] a_out, b_out;
  logic       a_valid, b_valid;
  logic [2:0] a_sel, b_sel;
  logic       a_cont, b_cont;
  logic       a_sticky, b_sticky;
  logic [1:0] a_cnt;
  logic [7:0] b_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] out;
    logic [2:0] sel;
    logic       valid;
    logic       cont;
    logic       sticky;
    logic [1:0] cnt;
    logic [7:0] out0;
    logic [7:0] cnt8;
  } exp_t;

  exp_t obs;
  exp_t m;
  exp_t e;
  exp_t sb[$];

  assign obs = {a_out, a_sel, a_valid, a_cont, a_sticky, a_cnt, b_out, b_cnt};

  always #5 clk = ~clk;

  sap_bus_arbiter #(
    .WIDTH (8),
    .NSRC  (5),
    .HOLD  (1),
    .CNTW  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .src_data    (src_data),
    .clr_err     (clr_err),
    .bus_out     (a_out),
    .bus_valid   (a_valid),
    .bus_sel     (a_sel),
    .contention  (a_cont),
    .cont_sticky (a_sticky),
    .cont_count  (a_cnt)
  );

  sap_bus_arbiter #(
    .WIDTH (8),
    .NSRC  (5),
    .HOLD  (0),
    .CNTW  (8)
  ) dut_h0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .src_data    (src_data),
    .clr_err     (clr_err),
    .bus_out     (b_out),
    .bus_valid   (b_valid),
    .bus_sel     (b_sel),
    .contention  (b_cont),
    .cont_sticky (b_sticky),
    .cont_count  (b_cnt)
  );

  task automatic model_reset();
    m = '0;
    sb.delete();
  endtask

  // Apply one cycle of stimulus, queue the expected result, step past the edge.
  task automatic drive(input logic [4:0] ev, input logic [39:0] d, input logic c);
    int g;
    en       = ev;
    src_data = d;
    clr_err  = c;
    g = -1;
    for (int i = 4; i >= 0; i--) if (ev[i]) g = i;
    if (g >= 0) begin
      m.out   = d[g*8 +: 8];
      m.out0  = d[g*8 +: 8];
      m.sel   = 3'(g);
      m.valid = 1'b1;
    end else begin
      m.valid = 1'b0;
      m.out0  = 8'h00;
    end
    m.cont = ($countones(ev) > 1);
    if (c) begin
      m.sticky = 1'b0;
      m.cnt    = 2'd0;
      m.cnt8   = 8'd0;
    end else if (m.cont) begin
      m.sticky = 1'b1;
      if (m.cnt != 2'd3) m.cnt = m.cnt + 2'd1;
      if (m.cnt8 != 8'hff) m.cnt8 = m.cnt8 + 8'd1;
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      en       = 5'($urandom);
      src_data = {8'($urandom), 32'($urandom)};
      clr_err  = 1'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_hold: got %h expected %h", obs, 32'h0);
      end
    end
    @(negedge clk);
    en      = '0;
    clr_err = 1'b0;
    rst_n   = 1'b1;
    model_reset();
    drive(5'b00000, 40'h0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", obs, e);
    end
    checks++;
    if (a_valid !== 1'b0 || a_out !== 8'h00 || b_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_const: got valid=%b out=%h expected valid=0 out=00",
               a_valid, a_out);
    end
  endtask

  task automatic test_single();
    drive(5'b00100, {8'h00, 8'h00, 8'hA5, 8'h00, 8'h00}, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL single: got %h expected %h", obs, e);
    end
    checks++;
    if (a_out !== 8'hA5 || a_sel !== 3'd2 || a_valid !== 1'b1 || a_cont !== 1'b0) begin
      errors++;
      $display("FAIL single_const: got out=%h sel=%0d valid=%b cont=%b expected A5 2 1 0",
               a_out, a_sel, a_valid, a_cont);
    end
  endtask

  task automatic test_idle();
    drive(5'b00000, {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A}, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL idle: got %h expected %h", obs, e);
    end
    checks++;
    if (a_valid !== 1'b0 || a_out !== 8'hA5 || b_out !== 8'h00 || a_sel !== 3'd2) begin
      errors++;
      $display("FAIL idle_const: got valid=%b out=%h out_h0=%h sel=%0d expected 0 A5 00 2",
               a_valid, a_out, b_out, a_sel);
    end
  endtask

  task automatic test_contention();
    drive(5'b10010, {8'h44, 8'h00, 8'h00, 8'h11, 8'h00}, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL contention: got %h expected %h", obs, e);
    end
    checks++;
    if (a_out !== 8'h11 || a_sel !== 3'd1 || a_cont !== 1'b1 || a_sticky !== 1'b1 ||
        a_cnt !== 2'd1 || b_cont !== 1'b1) begin
      errors++;
      $display("FAIL contention_const: got out=%h sel=%0d cont=%b sticky=%b cnt=%0d expected 11 1 1 1 1",
               a_out, a_sel, a_cont, a_sticky, a_cnt);
    end
    drive(5'b01000, {8'h00, 8'h33, 8'h00, 8'h00, 8'h00}, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL contention_after: got %h expected %h", obs, e);
    end
    checks++;
    if (a_cont !== 1'b0 || a_sticky !== 1'b1 || a_cnt !== 2'd1 || a_sel !== 3'd3) begin
      errors++;
      $display("FAIL contention_pulse: got cont=%b sticky=%b cnt=%0d sel=%0d expected 0 1 1 3",
               a_cont, a_sticky, a_cnt, a_sel);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 5; k++) begin
      drive(5'b00011 | 5'($urandom), {8'($urandom), 32'($urandom)}, 1'b0);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL saturate_%0d: got %h expected %h", k, obs, e);
      end
    end
    checks++;
    if (a_cnt !== 2'd3 || b_cnt !== 8'd6 || a_sticky !== 1'b1) begin
      errors++;
      $display("FAIL saturate_const: got cnt=%0d cnt8=%0d sticky=%b expected 3 6 1",
               a_cnt, b_cnt, a_sticky);
    end
    drive(5'b11000, {8'hC4, 8'hC3, 8'h00, 8'h00, 8'h00}, 1'b1);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL clear_with_cont: got %h expected %h", obs, e);
    end
    checks++;
    if (a_cnt !== 2'd0 || a_sticky !== 1'b0 || a_cont !== 1'b1 || b_cnt !== 8'd0 ||
        a_out !== 8'hC3) begin
      errors++;
      $display("FAIL clear_const: got cnt=%0d sticky=%b cont=%b out=%h expected 0 0 1 C3",
               a_cnt, a_sticky, a_cont, a_out);
    end
  endtask

  task automatic test_async_reset();
    drive(5'b00001, {8'h00, 8'h00, 8'h00, 8'h00, 8'h5A}, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL async_pre: got %h expected %h", obs, e);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0 || b_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: got %h expected %h", obs, 32'h0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL async_release: got %h expected %h", obs, 32'h0);
    end
    drive(5'b00001, {8'h00, 8'h00, 8'h00, 8'h00, 8'h77}, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL async_resume: got %h expected %h", obs, e);
    end
    checks++;
    if (a_out !== 8'h77 || a_valid !== 1'b1 || a_sel !== 3'd0) begin
      errors++;
      $display("FAIL async_resume_const: got out=%h valid=%b sel=%0d expected 77 1 0",
               a_out, a_valid, a_sel);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ev;
    for (int k = 0; k < 60; k++) begin
      ev = ($urandom_range(0, 3) == 0) ? 5'b00000 : 5'($urandom);
      drive(ev, {8'($urandom), 32'($urandom)}, ($urandom_range(0, 7) == 0));
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL back_to_back_%0d: en=%b got %h expected %h", k, ev, obs, e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_idle();
    test_contention();
    test_saturation();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
